// File: rtl/acc_job_scheduler.sv
// Job sequencer for the RLWE accumulator: accepts one command, waits for its ping-pong bank, counts polys, drains, reports.
// Optional watchdog is compiled in with `define ACC_SCHED_TIMEOUT_EN.
module acc_job_scheduler #(
  parameter int OPCODE_W  = 4,
  parameter int RLWE_ID_W = 8,
  parameter int DIGIT_W   = 5,
  parameter int CNT_W     = 6,
  parameter int TIMEOUT   = 4096,
  parameter logic [OPCODE_W-1:0] RLWESUBS = OPCODE_W'(3)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OPCODE_W-1:0]  cmd_opcode,
  input  logic [RLWE_ID_W-1:0] cmd_rlwe_id,
  input  logic [DIGIT_W-1:0]   cmd_digitG,
  input  logic [1:0]           bank_free,
  output logic                 acc_start,
  output logic [OPCODE_W-1:0]  acc_opcode,
  output logic [RLWE_ID_W-1:0] acc_rlwe_id,
  output logic                 acc_bank,
  input  logic                 acc_poly_done,
  input  logic                 acc_idle,
  output logic                 acc_abort,
  output logic                 job_done,
  output logic [RLWE_ID_W-1:0] job_rlwe_id,
  output logic                 job_bank,
  output logic                 cmd_err,
  output logic                 timeout_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CHECK = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] BUSY  = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]           state;
  logic                 bank_ptr;
  logic [CNT_W-1:0]     poly_cnt;
  logic [CNT_W-1:0]     exp_cnt;
  logic [CNT_W-1:0]     cmd_exp;
  logic [OPCODE_W-1:0]  opcode_q;
  logic [RLWE_ID_W-1:0] id_q;
  logic                 err_q;
  logic                 accept;
  logic                 abort_now;

  // A substitution job produces a single polynomial; others produce two per digit.
  assign cmd_exp   = (cmd_opcode == RLWESUBS) ? CNT_W'(1) : (CNT_W'(cmd_digitG) << 1);
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef ACC_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
  logic            in_watch;

  assign in_watch  = (state == BUSY) || (state == DRAIN);
  assign abort_now = in_watch && !acc_poly_done && (wd_cnt == WD_W'(TIMEOUT - 1));

  // Watchdog restarts whenever the accumulator shows progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ISSUE || acc_poly_done)
        wd_cnt <= '0;
      else if (in_watch)
        wd_cnt <= wd_cnt + WD_W'(1);
      if (abort_now)
        timeout_q <= 1'b1;
    end
  end

  assign acc_abort   = abort_now;
  assign timeout_err = timeout_q;
`else
  assign abort_now   = 1'b0;
  assign acc_abort   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bank_ptr <= 1'b0;
      poly_cnt <= '0;
      exp_cnt  <= '0;
      opcode_q <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            opcode_q <= cmd_opcode;
            id_q     <= cmd_rlwe_id;
            exp_cnt  <= cmd_exp;
            if (cmd_exp == '0)
              err_q <= 1'b1;
            else
              state <= CHECK;
          end
        end
        // Banks are strictly alternated, so only the current one is considered.
        CHECK: begin
          if (bank_free[bank_ptr])
            state <= ISSUE;
        end
        ISSUE: begin
          poly_cnt <= '0;
          state    <= BUSY;
        end
        BUSY: begin
          if (abort_now) begin
            state <= IDLE;
          end else if (acc_poly_done) begin
            poly_cnt <= poly_cnt + CNT_W'(1);
            if (poly_cnt == exp_cnt - CNT_W'(1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort_now)
            state <= IDLE;
          else if (acc_idle)
            state <= DONE;
        end
        DONE: begin
          bank_ptr <= ~bank_ptr;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign acc_start   = (state == ISSUE);
  assign acc_opcode  = opcode_q;
  assign acc_rlwe_id = id_q;
  assign acc_bank    = bank_ptr;
  assign job_done    = (state == DONE);
  assign job_rlwe_id = id_q;
  assign job_bank    = bank_ptr;
  assign cmd_err     = err_q;

endmodule
